hazard_scheduler: RTL
=====================

Name: hazard_scheduler

Overview:
- Pipeline hazard and stall controller for the 5-stage CPU.
- Sits beside the ID/EXE register and keeps its own shadow copy of the destination and write-enable info held in the EXE and MEM stages.
- Produces:
  - forwarding selects for the two ALU operand paths;
  - the load-use bubble (`lock_write` into ID/EXE);
  - the PC / IF-ID write enable;
  - a whole-pipeline freeze while data memory is not ready, with a timeout fault.

Parameters:
- MAX_WAIT, 16: number of consecutive memory-wait cycles after which the controller enters FAULT.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk, input, 1: clock, rising edge.
- clrn, input, 1: reset, asynchronous, active-low.
- id_rs, input, 5: rs field of the instruction in ID.
- id_rt, input, 5: rt field of the instruction in ID.
- id_use_rs, input, 1: the ID instruction reads rs.
- id_use_rt, input, 1: the ID instruction reads rt.
- id_wreg, input, 1: the ID instruction writes the register file.
- id_m2reg, input, 1: the ID instruction is a load.
- id_wmem, input, 1: the ID instruction is a store.
- id_rn, input, 5: destination register of the ID instruction.
- mem_ready, input, 1: data memory has completed the access presented by the MEM stage.
- fwd_a, output, 2: operand A select. 0 = register file, 1 = EXE ALU result, 2 = MEM ALU result, 3 = MEM load data.
- fwd_b, output, 2: operand B select, same encoding as fwd_a.
- stall, output, 1: load-use bubble; drives `lock_write` of ID/EXE.
- wpcir, output, 1: write enable for PC and IF/ID.
- freeze, output, 1: hold every pipeline register.
- mem_fault, output, 1: sticky memory-timeout flag.

Behaviour:
- Shadow registers: ex_wreg, ex_m2reg, ex_wmem, ex_rn, mm_wreg, mm_m2reg, mm_wmem, mm_rn.
- On clrn low: all shadow registers 0, state RUN, wait counter 0. All outputs therefore read 0, except wpcir = 1.
- FSM states:
  - RUN: normal operation.
  - WAIT: MEM stage is waiting on memory.
  - FAULT: terminal until reset.
- mem_busy = (mm_m2reg | mm_wmem) & ~mem_ready. This is combinational.
- RUN:
  - If mem_busy: freeze = 1 this cycle; next state WAIT; counter <= 1.
  - Otherwise: freeze = 0.
- WAIT:
  - freeze = 1 whenever mem_busy.
  - mem_busy de-asserted: freeze = 0 this cycle, next state RUN, counter <= 0. The pipeline advances on this same edge.
  - Otherwise, if counter == MAX_WAIT: next state FAULT.
  - Otherwise: counter increments.
- FAULT:
  - freeze = 1 and mem_fault = 1 permanently; mem_ready is ignored.
  - Only clrn exits FAULT.
- Load-use condition: ex_wreg & ex_m2reg & (ex_rn != 0) & ((id_use_rs & ex_rn == id_rs) | (id_use_rt & ex_rn == id_rt)).
- stall = load-use condition & ~freeze. Freeze dominates, so no bubble is ever injected during a freeze.
- wpcir = ~stall & ~freeze.
- Shadow register update, rising edge, only when freeze = 0:
  - mm_* <= ex_*.
  - If stall: ex_wreg, ex_m2reg, ex_wmem <= 0 (bubble), and ex_rn holds.
  - Otherwise: ex_* <= id_*.
- When freeze = 1, all shadow registers hold.
- Forwarding for fwd_a (fwd_b identical, using id_rt), combinational, in priority order:
  1. If ex_wreg & ~ex_m2reg & ex_rn != 0 & ex_rn == id_rs: select 1.
  2. Else, if mm_wreg & mm_rn != 0 & mm_rn == id_rs: select 3 when mm_m2reg, otherwise select 2.
  3. Else: select 0.
- Forwarding outputs are valid regardless of stall or freeze. Consumers ignore them while stalled.
- Register 0 is never forwarded and never causes a stall.
- Reset asserted mid-WAIT or mid-FAULT returns the controller to RUN immediately and clears mem_fault.

Test Plan:
- After reset, with no hazards:
  - fwd_a = fwd_b = 0, stall = 0, wpcir = 1, freeze = 0, mem_fault = 0.
- ALU RAW, EXE distance:
  - Issue "add r3" (id_wreg = 1, id_rn = 3); next cycle ID has id_rs = 3, id_use_rs = 1 → fwd_a = 1, stall = 0.
  - One cycle later, with a non-writing instruction in between → fwd_a = 2.
- Load-use:
  - Issue a load to r5; next ID has id_rt = 5, id_use_rt = 1 → stall = 1, wpcir = 0 for exactly 1 cycle.
  - Following cycle: fwd_b = 3, stall = 0.
- r0 destination:
  - A load with id_rn = 0 followed by a reader of r0 → stall = 0, fwd = 0.
- Memory wait:
  - Load in MEM with mem_ready = 0 for 3 cycles → freeze = 1 and wpcir = 0 for those 3 cycles, and shadow registers hold.
  - mem_ready = 1 → freeze drops the same cycle and the pipeline advances on that edge.
  - A load-use hazard present during the freeze must not raise stall until the freeze ends.
- Timeout:
  - With MAX_WAIT = 4, hold mem_ready = 0 → mem_fault rises after the counter reaches 4, and freeze stays 1 after mem_ready returns to 1.
  - Pulsing clrn low → all outputs return to their reset values.

Source files
------------

// File: rtl/hazard_scheduler.sv
// Hazard and stall controller for the 5-stage pipeline.
// Keeps a shadow copy of the EXE/MEM destination info and produces the
// operand forwarding selects, the load-use bubble, the PC/IF-ID write
// enable, and a whole-pipeline freeze while data memory is busy.
// A memory access that stays busy too long parks the controller in FAULT
// until reset.
//
// Handshake: mem_ready is a level qualifier for the access held in MEM.
// The access completes on the first rising edge at which mem_ready is 1.
// While a MEM load/store sees mem_ready = 0, freeze holds every pipeline
// register, including the shadow copies kept here.
module hazard_scheduler #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_wreg,
    input  logic       id_m2reg,
    input  logic       id_wmem,
    input  logic [4:0] id_rn,
    input  logic       mem_ready,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       stall,
    output logic       wpcir,
    output logic       freeze,
    output logic       mem_fault
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nx;

    // Shadow copy of the EXE and MEM stage destination/control bits
    logic       ex_wreg;
    logic       ex_m2reg;
    logic       ex_wmem;
    logic [4:0] ex_rn;
    logic       mm_wreg;
    logic       mm_m2reg;
    logic       mm_wmem;
    logic [4:0] mm_rn;

    logic mem_busy;
    logic load_use;

    // The access in MEM is a load or store still waiting on memory
    assign mem_busy = (mm_m2reg | mm_wmem) & ~mem_ready;

    // A load in EXE feeds a register the ID instruction actually reads
    assign load_use = ex_wreg & ex_m2reg & (ex_rn != 5'd0) &
                      ((id_use_rs & (ex_rn == id_rs)) |
                       (id_use_rt & (ex_rn == id_rt)));

    // Freeze dominates: no bubble is injected while the pipeline is held
    assign stall = load_use & ~freeze;
    assign wpcir = ~stall & ~freeze;

    // Forwarding select for one source register; EXE ALU result wins over MEM
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] e_rn,
        input logic       m_wreg,
        input logic       m_m2reg,
        input logic [4:0] m_rn
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (e_wreg && !e_m2reg && (e_rn != 5'd0) && (e_rn == src)) begin
            sel = 2'd1;
        end else if (m_wreg && (m_rn != 5'd0) && (m_rn == src)) begin
            sel = m_m2reg ? 2'd3 : 2'd2;
        end
        return sel;
    endfunction

    // Operand forwarding selects, valid every cycle regardless of stall/freeze
    always_comb begin
        fwd_a = fwd_sel(id_rs, ex_wreg, ex_m2reg, ex_rn, mm_wreg, mm_m2reg, mm_rn);
        fwd_b = fwd_sel(id_rt, ex_wreg, ex_m2reg, ex_rn, mm_wreg, mm_m2reg, mm_rn);
    end

    // Memory-wait FSM: next state, wait counter and freeze/fault outputs
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        freeze      = 1'b0;
        mem_fault   = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_busy) begin
                    freeze      = 1'b1;
                    state_nx    = ST_WAIT;
                    wait_cnt_nx = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!mem_busy) begin
                    state_nx    = ST_RUN;
                    wait_cnt_nx = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt == CNT_W'(MAX_WAIT)) begin
                        state_nx = ST_FAULT;
                    end else begin
                        wait_cnt_nx = wait_cnt + CNT_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                freeze    = 1'b1;
                mem_fault = 1'b1;
            end
            default: begin
                state_nx    = ST_RUN;
                wait_cnt_nx = '0;
            end
        endcase
    end

    // FSM state and wait counter registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // Shadow pipeline: advance unless frozen; a stall turns EXE into a bubble
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ex_wreg  <= 1'b0;
            ex_m2reg <= 1'b0;
            ex_wmem  <= 1'b0;
            ex_rn    <= 5'd0;
            mm_wreg  <= 1'b0;
            mm_m2reg <= 1'b0;
            mm_wmem  <= 1'b0;
            mm_rn    <= 5'd0;
        end else if (!freeze) begin
            mm_wreg  <= ex_wreg;
            mm_m2reg <= ex_m2reg;
            mm_wmem  <= ex_wmem;
            mm_rn    <= ex_rn;
            if (stall) begin
                ex_wreg  <= 1'b0;
                ex_m2reg <= 1'b0;
                ex_wmem  <= 1'b0;
            end else begin
                ex_wreg  <= id_wreg;
                ex_m2reg <= id_m2reg;
                ex_wmem  <= id_wmem;
                ex_rn    <= id_rn;
            end
        end
    end

endmodule
